// File: rtl/dfp128_pack_seq_pkg.sv
// Shared types and constants for the decimal128 DPD packer.
// Optional non-BCD digit check is compiled in with DFP_PACK_BCD_CHECK_EN.
package dfp128_pack_seq_pkg;

    localparam int unsigned DFP128_W    = 128;
    localparam int unsigned DFP_EXP_W   = 14;
    localparam int unsigned DFP_SIG_W   = 136;
    localparam int unsigned DFP_DIGITS  = 34;
    localparam int unsigned DFP_DECLETS = 11;
    localparam int unsigned DFP_HDR_W   = 18;
    localparam int unsigned DFP_CNT_W   = 4;

    localparam int unsigned        DFP128_BIAS = 6176;
    localparam logic [DFP_EXP_W-1:0] DFP128_EMAX = 14'h2FFF;
    localparam logic [4:0]         DFP_G_INF   = 5'b11110;
    localparam logic [4:0]         DFP_G_NAN   = 5'b11111;

    typedef logic [DFP128_W-1:0] dfp128_t;

    // Unpacked, rounded result as delivered by the round stage
    typedef struct packed {
        logic                 sign;
        logic [DFP_EXP_W-1:0] exp;
        logic [DFP_SIG_W-1:0] sig;
        logic                 nan;
        logic                 snan;
        logic                 inf;
    } dfp128_unp_t;

    typedef enum logic [1:0] {
        IDLE,
        ENC,
        DONE
    } dfp_pack_state_t;

    function automatic logic has_non_bcd(input logic [DFP_SIG_W-1:0] sig);
        for (int i = 0; i < int'(DFP_DIGITS); i++) begin
            if (sig[4*i +: 4] > 4'd9) return 1'b1;
        end
        return 1'b0;
    endfunction

endpackage

// File: rtl/dfp_bcd3_to_dpd.sv
// Three BCD digits to one canonical densely-packed-decimal declet.
module dfp_bcd3_to_dpd (
    input  logic [11:0] bcd,
    output logic [9:0]  dpd_c
);

    logic a, b, c, d, e, f, g, h, i, j, k, m;

    assign {a, b, c, d} = bcd[11:8];
    assign {e, f, g, h} = bcd[7:4];
    assign {i, j, k, m} = bcd[3:0];

    // Large-digit flags a/e/i select which small bits get relocated
    always_comb begin
        dpd_c = '0;
        case ({a, e, i})
            3'b000: dpd_c = {b, c, d, f, g, h, 1'b0, j, k, m};
            3'b001: dpd_c = {b, c, d, f, g, h, 1'b1, 2'b00, m};
            3'b010: dpd_c = {b, c, d, j, k, h, 1'b1, 2'b01, m};
            3'b100: dpd_c = {j, k, d, f, g, h, 1'b1, 2'b10, m};
            3'b110: dpd_c = {j, k, d, 2'b00, h, 1'b1, 2'b11, m};
            3'b101: dpd_c = {f, g, d, 2'b01, h, 1'b1, 2'b11, m};
            3'b011: dpd_c = {b, c, d, 2'b10, h, 1'b1, 2'b11, m};
            3'b111: dpd_c = {2'b00, d, 2'b11, h, 1'b1, 2'b11, m};
            default: dpd_c = '0;
        endcase
    end

endmodule

// File: rtl/dfp128_pack_seq.sv
// Sequential decimal128 DPD packer, DPC declets per cycle behind a valid/ready handshake.
// Define DFP_PACK_BCD_CHECK_EN to flag non-BCD coefficients as invalid (quiet NaN, o_inv).
module dfp128_pack_seq
    import dfp128_pack_seq_pkg::*;
#(
    parameter int unsigned DPC = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ce,
    input  logic                 i_valid,
    output logic                 i_ready,
    input  logic                 i_sign,
    input  logic [DFP_EXP_W-1:0] i_exp,
    input  logic [DFP_SIG_W-1:0] i_sig,
    input  logic                 i_nan,
    input  logic                 i_snan,
    input  logic                 i_inf,
    output logic                 o_valid,
    input  logic                 o_ready,
    output dfp128_t              o,
    output logic                 o_ovf,
    output logic                 o_inv
);

    localparam int unsigned COEF_W = 12 * DFP_DECLETS;
    localparam logic [DFP_CNT_W-1:0] CNT_STEP = DFP_CNT_W'(DPC);
    localparam logic [DFP_CNT_W-1:0] CNT_LAST = DFP_CNT_W'(DFP_DECLETS - DPC);

    if (DPC != 1 && DPC != 11) begin : g_bad_dpc
        $error("dfp128_pack_seq: DPC must be 1 or 11");
    end

    dfp_pack_state_t       state_q, state_d;
    logic [DFP_CNT_W-1:0]  cnt_q, cnt_d;
    logic [COEF_W-1:0]     sig_q, sig_d;
    logic                  i_ready_d, o_valid_d, o_ovf_d, o_inv_d;
    dfp128_t               o_d;

    dfp128_unp_t           in_c;
    logic [DFP_HDR_W-1:0]  hdr_c;
    logic [4:0]            g_c;
    logic [11:0]           cont_c;
    logic                  zero_c, ovf_c, inv_c, bad_c;

    logic [DFP_CNT_W-1:0]  k_c   [DPC];
    logic [9:0]            dpd_c [DPC];

    assign in_c = {i_sign, i_exp, i_sig, i_nan, i_snan, i_inf};

`ifdef DFP_PACK_BCD_CHECK_EN
    assign bad_c = has_non_bcd(in_c.sig) & ~in_c.nan & ~in_c.inf;
`else
    assign bad_c = 1'b0;
`endif

    // Header and coefficient policy, priority NaN > inf > invalid > overflow > finite
    always_comb begin
        g_c    = {in_c.exp[13:12], in_c.sig[134:132]};
        cont_c = in_c.exp[11:0];
        zero_c = 1'b0;
        ovf_c  = 1'b0;
        inv_c  = 1'b0;
        if (in_c.nan) begin
            g_c    = DFP_G_NAN;
            cont_c = {in_c.snan, 11'b0};
        end else if (in_c.inf) begin
            g_c    = DFP_G_INF;
            cont_c = '0;
            zero_c = 1'b1;
        end else if (bad_c) begin
            g_c    = DFP_G_NAN;
            cont_c = '0;
            zero_c = 1'b1;
            inv_c  = 1'b1;
        end else if (in_c.exp > DFP128_EMAX) begin
            g_c    = DFP_G_INF;
            cont_c = '0;
            zero_c = 1'b1;
            ovf_c  = 1'b1;
        end else if (in_c.sig[135]) begin
            g_c    = {2'b11, in_c.exp[13:12], in_c.sig[132]};
        end
        hdr_c = {in_c.sign, g_c, cont_c};
    end

    for (genvar j = 0; j < int'(DPC); j++) begin : g_enc
        assign k_c[j] = cnt_q + DFP_CNT_W'(j);
        dfp_bcd3_to_dpd u_dpd (
            .bcd   (sig_q[12*int'(k_c[j]) +: 12]),
            .dpd_c (dpd_c[j])
        );
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sig_d     = sig_q;
        i_ready_d = i_ready;
        o_valid_d = o_valid;
        o_d       = o;
        o_ovf_d   = o_ovf;
        o_inv_d   = o_inv;
        if (ce) begin
            case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        o_d       = {hdr_c, {(DFP128_W-DFP_HDR_W){1'b0}}};
                        sig_d     = zero_c ? '0 : in_c.sig[COEF_W-1:0];
                        o_ovf_d   = ovf_c;
                        o_inv_d   = inv_c;
                        i_ready_d = 1'b0;
                        cnt_d     = '0;
                        state_d   = ENC;
                    end
                end
                ENC: begin
                    for (int j = 0; j < int'(DPC); j++) begin
                        o_d[10*int'(k_c[j]) +: 10] = dpd_c[j];
                    end
                    if (cnt_q == CNT_LAST) begin
                        cnt_d     = '0;
                        o_valid_d = 1'b1;
                        state_d   = DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_STEP;
                    end
                end
                DONE: begin
                    if (o_ready) begin
                        o_valid_d = 1'b0;
                        i_ready_d = 1'b1;
                        state_d   = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sig_q   <= '0;
            i_ready <= 1'b1;
            o_valid <= 1'b0;
            o       <= '0;
            o_ovf   <= 1'b0;
            o_inv   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sig_q   <= sig_d;
            i_ready <= i_ready_d;
            o_valid <= o_valid_d;
            o       <= o_d;
            o_ovf   <= o_ovf_d;
            o_inv   <= o_inv_d;
        end
    end

endmodule

// File: tb/tb_dfp128_pack_seq.sv
// Directed bench for dfp128_pack_seq (DPC=1) with hand-computed decimal128 encodings.
module tb_dfp128_pack_seq;

    logic         clk = 1'b0;
    logic         rst_n, ce, i_valid, i_ready, i_sign, i_nan, i_snan, i_inf;
    logic         o_valid, o_ready, o_ovf, o_inv;
    logic [13:0]  i_exp;
    logic [135:0] i_sig;
    logic [127:0] o;

    int total  = 0;
    int passed = 0;
    int fails  = 0;
    int lat;

    logic [135:0] nines;
    logic [135:0] nines123;

    dfp128_pack_seq #(.DPC(1)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ce      (ce),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .i_sign  (i_sign),
        .i_exp   (i_exp),
        .i_sig   (i_sig),
        .i_nan   (i_nan),
        .i_snan  (i_snan),
        .i_inf   (i_inf),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o       (o),
        .o_ovf   (o_ovf),
        .o_inv   (o_inv)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic s, input logic [13:0] e, input logic [135:0] sg,
                        input logic nan, input logic snan, input logic inf);
        int n = 0;
        @(negedge clk);
        while (i_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        i_valid = 1'b1;
        i_sign  = s;
        i_exp   = e;
        i_sig   = sg;
        i_nan   = nan;
        i_snan  = snan;
        i_inf   = inf;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic wait_valid(input int start, output int l);
        l = start;
        while (o_valid !== 1'b1 && l < 200) begin
            @(posedge clk);
            #1;
            l++;
        end
    endtask

    task automatic run(input logic s, input logic [13:0] e, input logic [135:0] sg,
                       input logic nan, input logic snan, input logic inf, output int l);
        send(s, e, sg, nan, snan, inf);
        wait_valid(1, l);
    endtask

    task automatic pop();
        @(negedge clk);
        o_ready = 1'b1;
        @(posedge clk);
        #1;
        o_ready = 1'b0;
    endtask

    initial begin
        nines    = {34{4'h9}};
        nines123 = {{31{4'h9}}, 12'h123};
        rst_n   = 1'b0;
        ce      = 1'b1;
        i_valid = 1'b0;
        o_ready = 1'b0;
        i_sign  = 1'b0;
        i_exp   = '0;
        i_sig   = '0;
        i_nan   = 1'b0;
        i_snan  = 1'b0;
        i_inf   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_i_ready", 128'(i_ready), 128'd1);
        check("rst_o_valid", 128'(o_valid), 128'd0);
        check("rst_o",       o,             128'd0);
        check("rst_o_ovf",   128'(o_ovf),   128'd0);
        check("rst_o_inv",   128'(o_inv),   128'd0);
        rst_n = 1'b1;

        // Coefficient 1, exponent 0x1820
        run(1'b0, 14'h1820, 136'h1, 1'b0, 1'b0, 1'b0, lat);
        check("one_latency", 128'(lat), 128'd12);
        check("one_o", o, 128'h2208_0000_0000_0000_0000_0000_0000_0001);
        check("one_ovf", 128'(o_ovf), 128'd0);
        check("one_inv", 128'(o_inv), 128'd0);
        check("one_i_ready_done", 128'(i_ready), 128'd0);
        pop();
        check("pop_o_valid", 128'(o_valid), 128'd0);
        check("pop_i_ready", 128'(i_ready), 128'd1);

        run(1'b1, 14'h1820, nines, 1'b0, 1'b0, 1'b0, lat);
        check("nines_o", o, {1'b1, 5'b11011, 12'h820, {11{10'h0FF}}});
        pop();

        run(1'b1, 14'h1820, nines123, 1'b0, 1'b0, 1'b0, lat);
        check("d123_o", o, {1'b1, 5'b11011, 12'h820, {10{10'h0FF}}, 10'h0A3});
        pop();

        run(1'b0, 14'h1820, {4'h8, 132'h0}, 1'b0, 1'b0, 1'b0, lat);
        check("msd8_o", o, {1'b0, 5'b11010, 12'h820, 110'h0});
        pop();

        run(1'b0, 14'h1820, {4'h7, 132'h0}, 1'b0, 1'b0, 1'b0, lat);
        check("msd7_o", o, {1'b0, 5'b01111, 12'h820, 110'h0});
        pop();

        run(1'b1, 14'h1820, 136'h12345, 1'b0, 1'b0, 1'b1, lat);
        check("inf_o", o, 128'hF800_0000_0000_0000_0000_0000_0000_0000);
        check("inf_ovf", 128'(o_ovf), 128'd0);
        pop();

        run(1'b0, 14'h0, 136'h0, 1'b1, 1'b1, 1'b0, lat);
        check("snan_o", o, 128'h7E00_0000_0000_0000_0000_0000_0000_0000);
        pop();

        // NaN payload keeps the low 33 digits; the top digit is dropped
        run(1'b1, 14'h0, {4'h5, 120'h0, 12'h123}, 1'b1, 1'b0, 1'b0, lat);
        check("qnan_payload_o", o, 128'hFC00_0000_0000_0000_0000_0000_0000_00A3);
        pop();

        run(1'b1, 14'h3000, 136'h5, 1'b0, 1'b0, 1'b0, lat);
        check("ovf_o", o, 128'hF800_0000_0000_0000_0000_0000_0000_0000);
        check("ovf_flag", 128'(o_ovf), 128'd1);
        pop();

        run(1'b0, 14'h2FFF, 136'h0, 1'b0, 1'b0, 1'b0, lat);
        check("emax_o", o, 128'h43FF_C000_0000_0000_0000_0000_0000_0000);
        check("emax_ovf", 128'(o_ovf), 128'd0);
        // Backpressure: result must hold while o_ready is low
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check("bp_o_valid", 128'(o_valid), 128'd1);
            check("bp_i_ready", 128'(i_ready), 128'd0);
            check("bp_o", o, 128'h43FF_C000_0000_0000_0000_0000_0000_0000);
        end
        pop();

        // ce low for 4 cycles mid-encode stretches latency to 16
        send(1'b0, 14'h1820, 136'h1, 1'b0, 1'b0, 1'b0);
        lat = 1;
        repeat (3) begin
            @(posedge clk);
            #1;
            lat++;
        end
        ce = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("ce_hold_o_valid", 128'(o_valid), 128'd0);
        ce = 1'b1;
        wait_valid(lat, lat);
        check("ce_latency", 128'(lat), 128'd16);
        check("ce_o", o, 128'h2208_0000_0000_0000_0000_0000_0000_0001);
        ce     = 1'b0;
        o_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("ce_done_hold", 128'(o_valid), 128'd1);
        ce = 1'b1;
        @(posedge clk);
        #1;
        o_ready = 1'b0;
        check("ce_done_release", 128'(o_valid), 128'd0);

        // Asynchronous reset in the middle of an encode
        send(1'b1, 14'h1820, nines, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_o",       o,             128'd0);
        check("midrst_o_valid", 128'(o_valid), 128'd0);
        check("midrst_i_ready", 128'(i_ready), 128'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run(1'b0, 14'h1820, 136'h1, 1'b0, 1'b0, 1'b0, lat);
        check("postrst_latency", 128'(lat), 128'd12);
        check("postrst_o", o, 128'h2208_0000_0000_0000_0000_0000_0000_0001);
        pop();

`ifdef DFP_PACK_BCD_CHECK_EN
        run(1'b0, 14'h1820, {{33{4'h1}}, 4'hA}, 1'b0, 1'b0, 1'b0, lat);
        check("bcd_inv_flag", 128'(o_inv), 128'd1);
        check("bcd_inv_o", o, 128'h7C00_0000_0000_0000_0000_0000_0000_0000);
        pop();
        run(1'b0, 14'h1820, 136'h1, 1'b0, 1'b0, 1'b0, lat);
        check("bcd_inv_clear", 128'(o_inv), 128'd0);
        pop();
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
